// File: rtl/mdu_stage_e_pkg.sv
// Shared multiply/divide definitions: MDOP_* operation codes and MDU FSM state encodings.
package mdu_stage_e_pkg;

  localparam logic [3:0] MDOP_NOP   = 4'd0;
  localparam logic [3:0] MDOP_MULT  = 4'd1;
  localparam logic [3:0] MDOP_MULTU = 4'd2;
  localparam logic [3:0] MDOP_DIV   = 4'd3;
  localparam logic [3:0] MDOP_DIVU  = 4'd4;
  localparam logic [3:0] MDOP_MTHI  = 4'd5;
  localparam logic [3:0] MDOP_MTLO  = 4'd6;
  localparam logic [3:0] MDOP_MADD  = 4'd7;
  localparam logic [3:0] MDOP_MADDU = 4'd8;
  localparam logic [3:0] MDOP_MSUB  = 4'd9;
  localparam logic [3:0] MDOP_MSUBU = 4'd10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_stage_e_calc.sv
// Combinational mult/div datapath: {HI,LO} result for the op plus accept/latency-class flags.
// Multiply-accumulate codes are decoded only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_stage_e_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         i_mdop,
  input  logic [WIDTH-1:0]   i_data1,
  input  logic [WIDTH-1:0]   i_data2,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_is_long,
  output logic               o_is_div
);

  logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_quo_u, w_rem_u, w_a_abs, w_b_abs, w_mag_q, w_mag_r;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s;
  logic               w_b_zero;

  assign w_a_sx   = {{WIDTH{i_data1[WIDTH-1]}}, i_data1};
  assign w_b_sx   = {{WIDTH{i_data2[WIDTH-1]}}, i_data2};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {{WIDTH{1'b0}}, i_data1} * {{WIDTH{1'b0}}, i_data2};

  assign w_b_zero = (i_data2 == '0);
  assign w_quo_u  = w_b_zero ? '0 : i_data1 / i_data2;
  assign w_rem_u  = w_b_zero ? '0 : i_data1 % i_data2;

  // Sign-magnitude divide; MIN/-1 falls out naturally as quotient MIN, remainder 0.
  assign w_a_abs = i_data1[WIDTH-1] ? -i_data1 : i_data1;
  assign w_b_abs = i_data2[WIDTH-1] ? -i_data2 : i_data2;
  assign w_mag_q = w_b_zero ? '0 : w_a_abs / w_b_abs;
  assign w_mag_r = w_b_zero ? '0 : w_a_abs % w_b_abs;
  assign w_quo_s = (i_data1[WIDTH-1] ^ i_data2[WIDTH-1]) ? -w_mag_q : w_mag_q;
  assign w_rem_s = i_data1[WIDTH-1] ? -w_mag_r : w_mag_r;

  always_comb begin
    o_result  = {i_hi, i_lo};
    o_is_long = 1'b0;
    o_is_div  = 1'b0;
    case (i_mdop)
      MDOP_MULT: begin
        o_result  = w_prod_s;
        o_is_long = 1'b1;
      end
      MDOP_MULTU: begin
        o_result  = w_prod_u;
        o_is_long = 1'b1;
      end
      MDOP_DIV: begin
        o_result  = w_b_zero ? {i_data1, {WIDTH{1'b1}}} : {w_rem_s, w_quo_s};
        o_is_long = 1'b1;
        o_is_div  = 1'b1;
      end
      MDOP_DIVU: begin
        o_result  = w_b_zero ? {i_data1, {WIDTH{1'b1}}} : {w_rem_u, w_quo_u};
        o_is_long = 1'b1;
        o_is_div  = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDOP_MADD: begin
        o_result  = {i_hi, i_lo} + w_prod_s;
        o_is_long = 1'b1;
      end
      MDOP_MADDU: begin
        o_result  = {i_hi, i_lo} + w_prod_u;
        o_is_long = 1'b1;
      end
      MDOP_MSUB: begin
        o_result  = {i_hi, i_lo} - w_prod_s;
        o_is_long = 1'b1;
      end
      MDOP_MSUBU: begin
        o_result  = {i_hi, i_lo} - w_prod_u;
        o_is_long = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_stage_e.sv
// E-stage multiply/divide unit owning HI/LO; countdown models op latency (optional MDU_MADD_EN).
// Result is computed at Start into a pending register and committed on the final Busy cycle.
module mdu_stage_e
  import mdu_stage_e_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_pend;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic [2*WIDTH-1:0] w_result;
  logic               w_is_long, w_is_div;
  logic               w_idle_go, w_accept, w_done;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .i_mdop   (MDOp),
    .i_data1  (Data1),
    .i_data2  (Data2),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result),
    .o_is_long(w_is_long),
    .o_is_div (w_is_div)
  );

  assign w_idle_go = (r_state == MDU_IDLE) && Start && !Flush;
  assign w_accept  = w_idle_go && w_is_long;
  assign w_done    = (r_state == MDU_BUSY) && !Flush && (r_count == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_state_nxt = MDU_BUSY;
      MDU_BUSY: if (Flush || w_done) w_state_nxt = MDU_IDLE;
      default:  w_state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= MDU_IDLE;
      r_count <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pend  <= w_result;
        r_count <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (r_state == MDU_BUSY) begin
        if (Flush) begin
          r_count <= '0;
          r_pend  <= '0;
        end else begin
          r_count <= r_count - CW'(1);
        end
      end
      if (w_done) begin
        r_hi <= r_pend[2*WIDTH-1:WIDTH];
        r_lo <= r_pend[WIDTH-1:0];
      end
      if (w_idle_go && MDOp == MDOP_MTHI) r_hi <= Data1;
      if (w_idle_go && MDOp == MDOP_MTLO) r_lo <= Data1;
    end
  end

  assign Busy = (r_state == MDU_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_stage_e.sv
// Directed table-driven bench for mdu_stage_e plus flush/reset corner sequences.
module tb_mdu_stage_e;
  import mdu_stage_e_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush, Busy;
  logic [3:0]  MDOp;
  logic [31:0] Data1, Data2, HI, LO;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  mdu_stage_e #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .Flush(Flush),
    .Data1(Data1), .Data2(Data2), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic fl);
    @(negedge Clk);
    Start = 1'b1; MDOp = op; Data1 = d1; Data2 = d2; Flush = fl;
    @(negedge Clk);
    Start = 1'b0; MDOp = MDOP_NOP; Flush = 1'b0;
  endtask

  initial begin
    logic [31:0] hi_cur, lo_cur;
    logic        chg;
    int          n;

    vecs.push_back('{"mult_neg",   MDOP_MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{"divu_100_7", MDOP_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14});
    vecs.push_back('{"div_m7_2",   MDOP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_by0",    MDOP_DIV,   32'd5,        32'd0,        10, 32'd5,        32'hFFFFFFFF});
    vecs.push_back('{"div_minm1",  MDOP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000});
    vecs.push_back('{"multu_max",  MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_min2",  MDOP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000});
    vecs.push_back('{"divu_big",   MDOP_DIVU,  32'hFFFFFFFF, 32'd2,        10, 32'd1,        32'h7FFFFFFF});
    vecs.push_back('{"div_7_m2",   MDOP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"mthi",       MDOP_MTHI,  32'h00001234, 32'd0,        0,  32'h00001234, 32'hFFFFFFFD});
    vecs.push_back('{"mtlo",       MDOP_MTLO,  32'hFFFFFFFF, 32'd9,        0,  32'h00001234, 32'hFFFFFFFF});
    vecs.push_back('{"nop",        MDOP_NOP,   32'd3,        32'd4,        0,  32'h00001234, 32'hFFFFFFFF});
    vecs.push_back('{"reserved",   4'hF,       32'd3,        32'd4,        0,  32'h00001234, 32'hFFFFFFFF});
    vecs.push_back('{"mthi_zero",  MDOP_MTHI,  32'd0,        32'd0,        0,  32'd0,        32'hFFFFFFFF});
`ifdef MDU_MADD_EN
    vecs.push_back('{"maddu_1x1",  MDOP_MADDU, 32'd1,        32'd1,        5,  32'd1,        32'd0});
    vecs.push_back('{"msub_m1x1",  MDOP_MSUB,  32'hFFFFFFFF, 32'd1,        5,  32'd1,        32'd1});
`else
    vecs.push_back('{"maddu_off",  MDOP_MADDU, 32'd1,        32'd1,        0,  32'd0,        32'hFFFFFFFF});
    vecs.push_back('{"msub_off",   MDOP_MSUB,  32'hFFFFFFFF, 32'd1,        0,  32'd0,        32'hFFFFFFFF});
`endif

    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; MDOp = MDOP_NOP; Data1 = '0; Data2 = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    hi_cur = '0; lo_cur = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].d1, vecs[i].d2, 1'b0);
      n = 0; chg = 1'b0;
      while (Busy && n < 50) begin
        if (HI !== hi_cur || LO !== lo_cur) chg = 1'b1;
        n++;
        @(negedge Clk);
      end
      chk({vecs[i].name, "_cycles"}, n, vecs[i].cyc);
      chk({vecs[i].name, "_stable"}, {31'd0, chg}, 32'd0);
      chk({vecs[i].name, "_hi"}, HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, LO, vecs[i].lo);
      hi_cur = vecs[i].hi; lo_cur = vecs[i].lo;
    end

    // MULTU flushed on its third Busy cycle must leave HI/LO alone.
    issue(MDOP_MULTU, 32'd2, 32'd3, 1'b0);
    chk("flush_busy1", {31'd0, Busy}, 32'd1);
    @(negedge Clk);
    @(negedge Clk);
    chk("flush_busy3", {31'd0, Busy}, 32'd1);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("flush_busy_drop", {31'd0, Busy}, 32'd0);
    repeat (8) @(negedge Clk);
    chk("flush_hi", HI, hi_cur);
    chk("flush_lo", LO, lo_cur);

    issue(MDOP_MTLO, 32'hABCD0000, 32'd0, 1'b1);
    chk("flstart_mtlo_lo", LO, lo_cur);
    issue(MDOP_MTHI, 32'hABCD0000, 32'd0, 1'b1);
    chk("flstart_mthi_hi", HI, hi_cur);
    issue(MDOP_MULT, 32'd4, 32'd4, 1'b1);
    chk("flstart_mult_busy", {31'd0, Busy}, 32'd0);
    repeat (6) @(negedge Clk);
    chk("flstart_mult_lo", LO, lo_cur);

    // Reset in the middle of a divide discards the pending result.
    issue(MDOP_MTLO, 32'h55AA55AA, 32'd0, 1'b0);
    chk("pre_rst_lo", LO, 32'h55AA55AA);
    issue(MDOP_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (12) @(negedge Clk);
    chk("midrst_hi_late", HI, 32'd0);
    chk("midrst_lo_late", LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
